// File: rtl/rms_pkg.sv
// Shared types and widths for the RMS front end (mean_square_acc -> sqrt32).
package rms_pkg;

    // Result handshake state towards sqrt32.
    typedef enum logic [1:0] {
        FREE,
        START,
        WAIT
    } res_state_t;

    // Width of sample - offset: one bit wider than a 16-bit sample.
    localparam int DIFF_W = 17;
    // Width of the squared difference; 65535^2 still fits unsigned.
    localparam int SQ_W   = 32;

    // Accumulator width for a window of 2^log2n squares.
    function automatic int acc_w(input int log2n);
        return 32 + log2n;
    endfunction

endpackage

// File: rtl/sq_diff_stage.sv
// Stages 1-2 of the mean-square path: offset removal, then squaring.
// The valid bit travels alongside the data; clear/reset drop in-flight data.
module sq_diff_stage
    import rms_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       clear,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [SAMPLE_W-1:0] offset,
    input  logic                       sample_valid,
    output logic        [SQ_W-1:0]     sq_p2,
    output logic                       vld_p2
);

    logic signed [DIFF_W-1:0] diff_p1_q, diff_p1_d;
    logic                     vld_p1_q, vld_p1_d;
    logic        [SQ_W-1:0]   sq_p2_q, sq_p2_d;
    logic                     vld_p2_q, vld_p2_d;
    logic        [DIFF_W-1:0] mag;

    // Next-state for both stages: subtract on a valid sample, square the magnitude.
    always_comb begin
        vld_p1_d  = sample_valid;
        diff_p1_d = diff_p1_q;
        if (sample_valid) begin
            diff_p1_d = $signed({sample[SAMPLE_W-1], sample})
                      - $signed({offset[SAMPLE_W-1], offset});
        end
        // |diff| is at most 65535, so squaring the magnitude in 32 bits never wraps.
        mag = diff_p1_q[DIFF_W-1] ? $unsigned(-diff_p1_q) : $unsigned(diff_p1_q);
        vld_p2_d = vld_p1_q;
        sq_p2_d  = vld_p1_q ? (SQ_W'(mag) * SQ_W'(mag)) : sq_p2_q;
        if (clear) begin
            vld_p1_d  = 1'b0;
            diff_p1_d = '0;
            vld_p2_d  = 1'b0;
            sq_p2_d   = '0;
        end
    end

    // Pipeline registers for stage 1 (difference) and stage 2 (square).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            diff_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            sq_p2_q   <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            diff_p1_q <= diff_p1_d;
            vld_p1_q  <= vld_p1_d;
            sq_p2_q   <= sq_p2_d;
            vld_p2_q  <= vld_p2_d;
        end
    end

    assign sq_p2  = sq_p2_q;
    assign vld_p2 = vld_p2_q;

endmodule

// File: rtl/mean_square_acc.sv
// Mean-square accumulator feeding sqrt32: accumulates 2^LOG2_N squared,
// offset-corrected samples and hands the truncated mean over with a start pulse.
// LOG2_N must lie in 1..8.
module mean_square_acc
    import rms_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int LOG2_N   = 4
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       clear,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] offset,
    output logic        [31:0]         ms_out,
    output logic                       ms_start,
    input  logic                       sqrt_rdy,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACC_W = acc_w(LOG2_N);

    logic [SQ_W-1:0]   sq_p2;
    logic              vld_p2;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    res_state_t        state_q, state_d;
    logic [31:0]       ms_out_q, ms_out_d;
    logic              overrun_q, overrun_d;
    logic              rdy_prev_q, rdy_prev_d;
    logic              done;
    logic              rdy_rise;
    logic [31:0]       mean;

    sq_diff_stage #(
        .SAMPLE_W (SAMPLE_W)
    ) u_sq_diff (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .clear        (clear),
        .sample       (sample),
        .offset       (offset),
        .sample_valid (sample_valid),
        .sq_p2        (sq_p2),
        .vld_p2       (vld_p2)
    );

    // Stage 3 accumulation and the result handshake with sqrt32.
    always_comb begin
        acc_next   = acc_q + ACC_W'(sq_p2);
        mean       = acc_next[LOG2_N +: 32];
        done       = vld_p2 && (&cnt_q);
        rdy_rise   = sqrt_rdy && !rdy_prev_q;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        ms_out_d   = ms_out_q;
        overrun_d  = overrun_q;
        rdy_prev_d = sqrt_rdy;

        // Bubbles leave acc/cnt alone; the closing square restarts the window.
        if (vld_p2) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = done ? '0 : acc_next;
        end

        case (state_q)
            FREE: begin
                if (done) begin
                    ms_out_d = mean;
                    state_d  = START;
                end
            end
            START: begin
                state_d = WAIT;
                if (done) overrun_d = 1'b1;
            end
            WAIT: begin
                // A release coinciding with a new window hands the new result straight over.
                if (rdy_rise && done) begin
                    ms_out_d = mean;
                    state_d  = START;
                end else if (rdy_rise) begin
                    state_d = FREE;
                end else if (done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = FREE;
        endcase

        if (clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = FREE;
            ms_out_d   = '0;
            overrun_d  = 1'b0;
        end
    end

    // State, accumulator and result registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= FREE;
            ms_out_q   <= '0;
            overrun_q  <= 1'b0;
            rdy_prev_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            ms_out_q   <= ms_out_d;
            overrun_q  <= overrun_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

    assign ms_out   = ms_out_q;
    assign ms_start = (state_q == START);
    assign busy     = (state_q != FREE);
    assign overrun  = overrun_q;

endmodule

// File: doc/mean_square_acc.md
# mean_square_acc

- Upstream feeder for `sqrt32`; together they form an RMS path.
- Subtracts a programmable offset from each signed ADC sample, squares the difference and accumulates 2^LOG2_N squares.
- Presents the truncated mean square as a 32-bit operand with a one-cycle start pulse.
- Holds that operand stable until `sqrt32` signals completion on its ready output.

## Interface
- `SAMPLE_W`, default 16: signed sample width; fixed at 16 so the squared difference fits 32 bits.
- `LOG2_N`, default 4: window length N = 2^LOG2_N samples; legal range 1..8.
- `CLK`  in  1: sole clock; all logic on rising edge.
- `RST_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear, same effect as reset.
- `sample`  in  SAMPLE_W: signed ADC sample.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `offset`  in  SAMPLE_W: signed DC offset, sampled together with `sample`.
- `ms_out`  out  32: mean square, drives `sqrt32.x`.
- `ms_start`  out  1: one-cycle start pulse, drives the `sqrt32` start/reset input.
- `sqrt_rdy`  in  1: `sqrt32.rdy`; a rising edge means the operand has been consumed.
- `busy`  out  1: a result is outstanding (START or WAIT state).
- `overrun`  out  1: sticky; a completed window was discarded.

## Operation
- Stage 1: `diff = sample - offset`, 17-bit signed, registered when `sample_valid`.
- Stage 2: `sq = diff*diff`, 32-bit unsigned.
  - Maximum is 65535² = 4294836225, so no saturation is needed.
- Stage 3 adds `sq` into `acc` (32+LOG2_N bits) and increments `cnt` (LOG2_N bits, wraps).
- When the N-th square is added:
  - `mean = acc_next[LOG2_N +: 32]`, truncating division.
  - `acc` and `cnt` clear in the same edge, so the next window accumulates back-to-back.
- Valid bits travel with the data through each stage.
- Cycles without `sample_valid` create pipeline bubbles and never add zero.
- Result FSM (enum in the package):
  - FREE: window completes → load `ms_out`, go to START.
  - START: `ms_start`=1 for exactly this cycle → WAIT.
  - WAIT: rising edge of `sqrt_rdy` (registered previous value) → FREE.
  - WAIT: window completes without that edge → result discarded, `ms_out` unchanged, `overrun`←1.
- Simultaneous events:
  - `sqrt_rdy` rising edge in the same cycle a window completes in WAIT: the new result is accepted, `ms_out` loads and the FSM goes to START.
  - A window completing in START: discarded, `overrun`←1.
- `clear`, or `RST_n` low, aborts everything, including a partial window and any in-flight pipeline data.
- Reset and clear values: `ms_out`=0, `ms_start`=0, `busy`=0, `overrun`=0, `acc`=0, `cnt`=0, state FREE.

## Timing
- The N-th valid sample is captured at edge E0.
- `ms_out` is updated and `ms_start` is high in the cycle following E2 (three edges, E0–E2).
- `ms_start` falls after E3.
- `ms_out` changes only on a FREE→START transition.
- Sustained throughput is one sample per cycle; no backpressure to the sample source.
- `sqrt_rdy` is treated as a level from `sqrt32`.
  - Only a 0→1 transition observed while in WAIT releases the result.
  - `sqrt_rdy` already high on entry to WAIT does not count.
- `RST_n` assertion clears all registers immediately.
- Deassertion is used synchronously by the logic; the first sample is accepted on the first edge after release.

## Structure
- Package `rms_pkg`:
  - `res_state_t` enum (FREE, START, WAIT).
  - `DIFF_W`=17 and `SQ_W`=32 localparams.
  - Function `acc_w(log2n)` returning 32+log2n.
- One sub-module, `sq_diff_stage`: stages 1–2 (subtract, square, valid pipeline), reset-capable.
- The top level holds the accumulator, counter and result FSM.

## Test plan
- Reset: hold `RST_n`=0 with random inputs → all outputs 0. Release → no `ms_start` without samples.
- Basic window, LOG2_N=4, `offset`=0, 16 consecutive samples of 5:
  - `ms_out`=25, one-cycle `ms_start` three edges after the 16th sample.
  - Pulse `sqrt_rdy` 0→1 → `busy`=0.
- Truncation and bubbles: samples 0..15 with random idle cycles between them → `ms_out`=77 (1240/16).
- Extremes: 16 samples of −32768 with `offset`=32767 → `ms_out`=4294836225, no wrap.
- Overrun:
  - Two back-to-back windows of 3 with no `sqrt_rdy` edge → `ms_out` stays 9, `overrun`=1.
  - A `sqrt_rdy` edge coincident with a third window completing → new value loads, `ms_start` pulses.
- Mid-window abort:
  - 8 samples of 7, then `RST_n` low for 2 cycles (repeat the sequence using `clear`), then 16 samples of 2.
  - Required: `ms_out`=4, exactly one `ms_start` pulse.
